// File: rtl/cond_logic.sv
// cond_logic: conditional-execution unit for a single-cycle ARM core.
// Holds the NZCV flag register and checks each instruction's condition
// field against the stored flags. Gates the decoder's PC, register and
// memory write requests, and keeps saturating executed/skipped counters.
module cond_logic #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [3:0]       Cond,
  input  logic [3:0]       ALUFlags,
  input  logic [1:0]       FlagW,
  input  logic             PCS,
  input  logic             RegW,
  input  logic             MemW,
  input  logic             NoWrite,
  input  logic             cnt_clr,
  output logic             CondEx,
  output logic             PCSrc,
  output logic             RegWrite,
  output logic             MemWrite,
  output logic [3:0]       Flags,
  output logic [CNT_W-1:0] exec_count,
  output logic [CNT_W-1:0] skip_count
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  // Evaluate a 4-bit ARM condition code against {N,Z,C,V}.
  // Code 1111 is treated as "never", so an unused encoding cannot
  // leak an unknown into the write strobes.
  function automatic logic cond_pass(input logic [3:0] cond,
                                     input logic [3:0] nzcv);
    logic n, z, c, v;
    logic pass;
    n = nzcv[3];
    z = nzcv[2];
    c = nzcv[1];
    v = nzcv[0];
    case (cond)
      4'b0000: pass = z;
      4'b0001: pass = ~z;
      4'b0010: pass = c;
      4'b0011: pass = ~c;
      4'b0100: pass = n;
      4'b0101: pass = ~n;
      4'b0110: pass = v;
      4'b0111: pass = ~v;
      4'b1000: pass = c & ~z;
      4'b1001: pass = ~c | z;
      4'b1010: pass = (n == v);
      4'b1011: pass = (n != v);
      4'b1100: pass = ~z & (n == v);
      4'b1101: pass = z | (n != v);
      4'b1110: pass = 1'b1;
      default: pass = 1'b0;
    endcase
    return pass;
  endfunction

  // Increment that sticks at the all-ones value instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] val);
    logic [CNT_W-1:0] res;
    if (&val) res = val;
    else      res = val + CNT_ONE;
    return res;
  endfunction

  logic       cond_ok;
  logic       exec_evt;
  logic       skip_evt;
  logic       wr_nz;
  logic       wr_cv;
  logic [3:0] flags_q;

  // Condition check uses only the registered flags; ALUFlags never
  // reaches an output combinationally.
  always_comb begin
    cond_ok  = cond_pass(Cond, flags_q);
    CondEx   = cond_ok & en;
    PCSrc    = PCS & CondEx;
    MemWrite = MemW & CondEx;
    RegWrite = RegW & CondEx & ~NoWrite;
    exec_evt = en & cond_ok;
    skip_evt = en & ~cond_ok;
    wr_nz    = CondEx & FlagW[1];
    wr_cv    = CondEx & FlagW[0];
  end

  // Flag register: N/Z and C/V halves are written independently so
  // logical ops can update N/Z while carrying C/V through.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      flags_q <= 4'b0000;
    end else begin
      if (wr_nz) flags_q[3:2] <= ALUFlags[3:2];
      if (wr_cv) flags_q[1:0] <= ALUFlags[1:0];
    end
  end

  assign Flags = flags_q;

  // Debug counters: clear wins over counting; an instruction is either
  // executed or skipped, so at most one counter moves per cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      exec_count <= '0;
      skip_count <= '0;
    end else if (cnt_clr) begin
      exec_count <= '0;
      skip_count <= '0;
    end else if (exec_evt) begin
      exec_count <= sat_inc(exec_count);
    end else if (skip_evt) begin
      skip_count <= sat_inc(skip_count);
    end
  end

endmodule

// File: tb/tb_cond_logic.sv
// Testbench for cond_logic: directed scenarios plus randomized traffic,
// compared every cycle against a behavioural model of the flag and
// counter rules.
module tb_cond_logic;

  localparam int CNT_W   = 2;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             en = 1'b0;
  logic [3:0]       Cond = 4'b0;
  logic [3:0]       ALUFlags = 4'b0;
  logic [1:0]       FlagW = 2'b0;
  logic             PCS = 1'b0;
  logic             RegW = 1'b0;
  logic             MemW = 1'b0;
  logic             NoWrite = 1'b0;
  logic             cnt_clr = 1'b0;
  logic             CondEx;
  logic             PCSrc;
  logic             RegWrite;
  logic             MemWrite;
  logic [3:0]       Flags;
  logic [CNT_W-1:0] exec_count;
  logic [CNT_W-1:0] skip_count;

  int checks   = 0;
  int failures = 0;

  cond_logic #(.CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .en(en), .Cond(Cond), .ALUFlags(ALUFlags),
    .FlagW(FlagW), .PCS(PCS), .RegW(RegW), .MemW(MemW), .NoWrite(NoWrite),
    .cnt_clr(cnt_clr), .CondEx(CondEx), .PCSrc(PCSrc), .RegWrite(RegWrite),
    .MemWrite(MemWrite), .Flags(Flags), .exec_count(exec_count),
    .skip_count(skip_count)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  bit [3:0] m_flags = 4'b0;
  int       m_exec  = 0;
  int       m_skip  = 0;

  function automatic bit model_pass(input logic [3:0] c, input logic [3:0] f);
    bit n, z, cy, v;
    n = f[3]; z = f[2]; cy = f[1]; v = f[0];
    case (c)
      4'd0:  return z;                 // EQ
      4'd1:  return !z;                // NE
      4'd2:  return cy;                // CS
      4'd3:  return !cy;               // CC
      4'd4:  return n;                 // MI
      4'd5:  return !n;                // PL
      4'd6:  return v;                 // VS
      4'd7:  return !v;                // VC
      4'd8:  return cy && !z;          // HI
      4'd9:  return !cy || z;          // LS
      4'd10: return n == v;            // GE
      4'd11: return n != v;            // LT
      4'd12: return !z && (n == v);    // GT
      4'd13: return z || (n != v);     // LE
      4'd14: return 1'b1;              // AL
      default: return 1'b0;            // never
    endcase
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_flags <= 4'b0;
      m_exec  <= 0;
      m_skip  <= 0;
    end else begin
      if (en && model_pass(Cond, m_flags)) begin
        m_flags <= {FlagW[1] ? ALUFlags[3:2] : m_flags[3:2],
                    FlagW[0] ? ALUFlags[1:0] : m_flags[1:0]};
      end
      if (cnt_clr) begin
        m_exec <= 0;
        m_skip <= 0;
      end else if (en && model_pass(Cond, m_flags)) begin
        m_exec <= (m_exec < CNT_MAX) ? m_exec + 1 : m_exec;
      end else if (en) begin
        m_skip <= (m_skip < CNT_MAX) ? m_skip + 1 : m_skip;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    bit cx;
    cx = en && model_pass(Cond, m_flags);
    chk("CondEx",     32'(CondEx),     32'(cx));
    chk("PCSrc",      32'(PCSrc),      32'(cx && PCS));
    chk("MemWrite",   32'(MemWrite),   32'(cx && MemW));
    chk("RegWrite",   32'(RegWrite),   32'(cx && RegW && !NoWrite));
    chk("Flags",      32'(Flags),      32'(m_flags));
    chk("exec_count", 32'(exec_count), 32'(m_exec));
    chk("skip_count", 32'(skip_count), 32'(m_skip));
  end

  // Apply one instruction just after a rising edge; returns 2 time units
  // in so directed checks land between the edges.
  task automatic drive(input logic e, input logic [3:0] c, input logic [3:0] af,
                       input logic [1:0] fw, input logic p, input logic r,
                       input logic m, input logic nw, input logic clr);
    @(posedge clk);
    #1;
    en = e; Cond = c; ALUFlags = af; FlagW = fw;
    PCS = p; RegW = r; MemW = m; NoWrite = nw; cnt_clr = clr;
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 4'h0, 4'h0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic set_flags(input logic [3:0] f);
    drive(1'b1, 4'hE, f, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #3 reset = 1'b0;
    #1;
    chk("rst_flags", 32'(Flags), 32'h0);
    chk("rst_exec",  32'(exec_count), 32'h0);
    chk("rst_skip",  32'(skip_count), 32'h0);

    // Basic gating from reset flags
    drive(1'b1, 4'h0, 4'h0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("eq_condex", 32'(CondEx), 32'h0);
    chk("eq_pcsrc",  32'(PCSrc),  32'h0);
    drive(1'b1, 4'hE, 4'h0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("al_condex", 32'(CondEx), 32'h1);
    chk("al_pcsrc",  32'(PCSrc),  32'h1);
    drive(1'b1, 4'hF, 4'h0, 2'b00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("nv_strobes", 32'({CondEx, PCSrc, RegWrite, MemWrite}), 32'h0);

    // SUBS-style flag set, then dependent conditions
    drive(1'b1, 4'hE, 4'b0100, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 4'h0, 4'h0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("subs_flags", 32'(Flags), 32'h4);
    chk("eq_regwrite", 32'(RegWrite), 32'h1);
    drive(1'b1, 4'h1, 4'h0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("ne_regwrite", 32'(RegWrite), 32'h0);

    // Split half writes
    set_flags(4'hF);
    drive(1'b1, 4'hE, 4'h0, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("pre_split", 32'(Flags), 32'hF);
    drive(1'b1, 4'hE, 4'h0, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("split_nz", 32'(Flags), 32'h3);
    idle();
    chk("split_cv", 32'(Flags), 32'h0);

    // CMP: flags written, register write suppressed
    drive(1'b1, 4'hE, 4'b0110, 2'b11, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    chk("cmp_regwrite", 32'(RegWrite), 32'h0);
    set_flags(4'h0);
    chk("cmp_flags", 32'(Flags), 32'h6);
    drive(1'b1, 4'h0, 4'hF, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    idle();
    chk("fail_noflag", 32'(Flags), 32'h0);

    // Full Cond x Flags sweep, with and without en
    for (int f = 0; f < 16; f++) begin
      set_flags(4'(f));
      for (int c = 0; c < 16; c++)
        drive(1'b1, 4'(c), 4'(~f), 2'b00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
      chk("sweep_flags", 32'(Flags), 32'(f));
      for (int c = 0; c < 16; c++)
        drive(1'b0, 4'(c), 4'(~f), 2'b11, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    end

    // Counter saturation and clear priority
    drive(1'b0, 4'h0, 4'h0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++)
      drive(1'b1, 4'hE, 4'h0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 4'hF, 4'h0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("exec_sat", 32'(exec_count), 32'h3);
    chk("skip_zero", 32'(skip_count), 32'h0);
    drive(1'b1, 4'hE, 4'h0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("skip_one", 32'(skip_count), 32'h1);
    idle();
    chk("clr_exec", 32'(exec_count), 32'h0);
    chk("clr_skip", 32'(skip_count), 32'h0);

    // Asynchronous reset pulse between edges
    drive(1'b1, 4'hE, 4'b1010, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 4'hF, 4'h0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    idle();
    chk("pre_rst_flags", 32'(Flags), 32'hA);
    reset = 1'b1;
    #1;
    chk("arst_flags", 32'(Flags), 32'h0);
    chk("arst_exec",  32'(exec_count), 32'h0);
    chk("arst_skip",  32'(skip_count), 32'h0);
    reset = 1'b0;

    // Randomized traffic with occasional clears and mid-cycle resets
    for (int i = 0; i < 600; i++) begin
      drive(($urandom_range(0, 7) != 0), 4'($urandom), 4'($urandom),
            2'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
            1'($urandom), ($urandom_range(0, 19) == 0));
      if ($urandom_range(0, 49) == 0) begin
        #1 reset = 1'b1;
        #1 reset = 1'b0;
      end
    end
    idle();
    @(posedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cond_logic.md
# cond_logic

Conditional-execution unit for the single-cycle ARM core, placed between the decoder and the datapath write ports. It holds the architectural NZCV flag register and evaluates the instruction's 4-bit condition field against the stored flags. It gates the decoder's PCS/RegW/MemW requests into the final PCSrc/RegWrite/MemWrite strobes. It also keeps saturating counters of executed and condition-skipped instructions for debug.

## Interface
- CNT_W, 32, width of each statistics counter (≥ 2)
- clk  in  1  core clock, all state updates on rising edge
- reset  in  1  asynchronous, active-high; clears flags and counters
- en  in  1  instruction valid this cycle; low = bubble/stall
- Cond  in  4  instruction condition field [31:28]
- ALUFlags  in  4  {N,Z,C,V} from the ALU for the current instruction
- FlagW  in  2  [1] = write N,Z; [0] = write C,V (from decoder)
- PCS  in  1  decoder requests PC write
- RegW  in  1  decoder requests register-file write
- MemW  in  1  decoder requests memory write
- NoWrite  in  1  compare-type op (CMP/CMN/TST/TEQ): suppress RegWrite
- cnt_clr  in  1  synchronous clear of both counters
- CondEx  out  1  condition passed for current instruction
- PCSrc  out  1  gated PC write
- RegWrite  out  1  gated register write
- MemWrite  out  1  gated memory write
- Flags  out  4  registered {N,Z,C,V}
- exec_count  out  CNT_W  instructions executed (en & CondEx)
- skip_count  out  CNT_W  instructions skipped (en & ~CondEx)

## Operation
- Condition evaluation uses the registered Flags (never ALUFlags), per the ARM encoding: 0000 EQ Z; 0001 NE ~Z; 0010 CS C; 0011 CC ~C; 0100 MI N; 0101 PL ~N; 0110 VS V; 0111 VC ~V; 1000 HI C&~Z; 1001 LS ~C|Z; 1010 GE N==V; 1011 LT N!=V; 1100 GT ~Z&(N==V); 1101 LE Z|(N!=V); 1110 AL 1.
- Cond = 1111 is treated as never-execute: CondEx = 0, no X propagation.
- CondEx output = cond_pass & en.
- PCSrc = PCS & CondEx; MemWrite = MemW & CondEx; RegWrite = RegW & CondEx & ~NoWrite.
- Flag update at rising edge: if CondEx & FlagW[1], Flags[3:2] ← ALUFlags[3:2]; if CondEx & FlagW[0], Flags[1:0] ← ALUFlags[1:0]. Halves are independent; unselected half holds.
- Failed-condition or en = 0 cycle: no flag change, all three strobes 0.
- Counters: if cnt_clr, both ← 0 (priority over increment). Else if en & CondEx, exec_count += 1; else if en & ~CondEx, skip_count += 1. Each saturates at 2^CNT_W − 1 (no wrap). At most one counter changes per cycle.

## Timing
- Reset (async assert, any time): Flags = 0000, exec_count = 0, skip_count = 0 immediately; combinational outputs then follow Flags = 0000 (e.g. Cond EQ → CondEx 0, Cond AL → 1 if en). Reset mid-instruction discards that instruction's flag write.
- Reset deassertion is synchronised externally; first update on the first rising edge with reset low.
- CondEx, PCSrc, RegWrite, MemWrite: combinational, zero-cycle latency from Cond/en/PCS/RegW/MemW/NoWrite/Flags; no combinational path from ALUFlags to any output.
- Flags, counters: one-cycle latency; an instruction's flag write is visible to the next instruction's condition.
- Back-to-back flag-setting instructions: each sees the flags from its predecessor only.
- cnt_clr and a counting event in the same cycle: counter reads 0 after the edge.

## Test plan
- Reset then Cond=0000, en=1, PCS=1 → CondEx=0, PCSrc=0; Cond=1110 → CondEx=1, PCSrc=1; Cond=1111 → all strobes 0.
- SUBS-style: Cond=1110, FlagW=11, ALUFlags=0100 → next cycle Flags=0100; then Cond=0000 RegW=1 → RegWrite=1, Cond=0001 → RegWrite=0.
- Split write: Flags=1111, FlagW=10, ALUFlags=0000 → Flags=0011; then FlagW=01, ALUFlags=0000 → Flags=0000.
- CMP with NoWrite=1, RegW=1, FlagW=11, Cond=1110 → RegWrite=0, flags updated; failing condition (Flags=0000, Cond=0000, FlagW=11, ALUFlags=1111) → Flags stay 0000.
- Sweep all 16 Cond × 16 Flags values against the table above, en=1; repeat with en=0 → CondEx=0 and no counter change.
- CNT_W=2: 5 executed instructions → exec_count=3 (saturated); 1 skipped → skip_count=1; cnt_clr with concurrent execution → both 0; async reset pulse between edges → Flags and counters 0 immediately.
